id_ex_latch: RTL
================

// Module: id_ex_latch
// PURPOSE
//  Decode->execute pipeline register of the 16-bit pipelined core. Captures the decoded
//  instruction bundle (extended immediate, register read data, dest reg, control word, PC+2).
//  Presents it to the execute stage one cycle later.
//  Handles stall (hold), flush (bubble insert), and a sticky halt state after a HALT is captured.
// PARAMETERS
//  DATA_W  16  width of data/immediate/PC fields
//  CTRL_W  12  width of packed execute/memory/writeback control word
// PORTS
//  clk          in   1        clock; all state updates on rising edge
//  rst          in   1        synchronous, active-high reset
//  stall        in   1        hazard unit: hold current contents
//  flush        in   1        branch/jump resolved: load bubble instead of id_* bundle
//  id_valid     in   1        decode slot holds a real instruction
//  id_instr     in   16       raw instruction word
//  id_pc_plus2  in   DATA_W   PC+2 of the decoded instruction
//  id_imm       in   DATA_W   immediate from the decode-stage immediate extender
//  id_rd1       in   DATA_W   register file read port 1
//  id_rd2       in   DATA_W   register file read port 2
//  id_wr_reg    in   3        destination register index
//  id_ctrl      in   CTRL_W   control word (0 = no side effects)
//  id_halt      in   1        instruction is HALT
//  ex_*         out  (same)   registered copies: ex_valid, ex_instr, ex_pc_plus2, ex_imm,
//                             ex_rd1, ex_rd2, ex_wr_reg, ex_ctrl, ex_halt
//  halted       out  1        core has captured a HALT; no further instructions accepted
// BEHAVIOUR
//  - Latency: one cycle; bundle present on id_* at edge N appears on ex_* after edge N.
//  - Bubble: ex_valid=0, ex_ctrl=0, ex_wr_reg=0, ex_halt=0.
//    Bubble data fields: ex_instr=16'h0800 (NOP), all others 0.
//  - Reset (rst=1 at edge): bubble on all ex_* outputs, halted=0, state=RUN.
//  - Per-edge priority: rst > stall > flush > load.
//    * stall=1: every ex_* and the state are held; flush is ignored that edge. The hazard
//      unit never asserts stall with a pending branch flush.
//    * flush=1, stall=0: load bubble.
//    * id_valid=0: load bubble. It does not matter what is on the other id_* fields.
//    * otherwise: load id_* bundle, ex_valid=1.
//  - State machine (2 states):
//    * RUN -> HALTED when a load edge captures id_valid=1 and id_halt=1.
//      The HALT bundle is visible on ex_* for that cycle.
//    * HALTED: each non-stall edge loads a bubble, regardless of id_*/flush.
//      A stall holds the HALT bundle in place. Only rst leaves HALTED.
//    * halted is high combinationally whenever state=HALTED.
//  - A flush and a HALT on the same edge: flush wins; the HALT is squashed; state stays RUN.
//  - Reset mid-stall or mid-HALTED: the reset value applies in full on that edge.
//  - No combinational path from id_* to ex_*. halted is driven from state only.
// CONFIGURATION
//  - STALL_CNT_EN defined: adds outputs stall_cycles[15:0] and flush_cycles[15:0].
//    * stall_cycles increments on each edge with stall=1 and rst=0.
//    * flush_cycles increments on each edge with flush=1, stall=0, rst=0.
//    * Both counters saturate at 16'hFFFF and clear to 0 on rst.
//    * Counters freeze while HALTED.
//  - STALL_CNT_EN undefined: counter ports and logic do not exist. All other behaviour is
//    identical.
// TESTING
//  1 rst=1 for 2 cycles, then release -> ex_valid=0, ex_instr=16'h0800, ex_ctrl=0, halted=0.
//  2 Load: id_valid=1, id_imm=16'hFFF5, id_rd1=16'h1234, id_wr_reg=3'd5, id_ctrl=12'h0A1
//    -> next cycle ex_imm=16'hFFF5, ex_rd1=16'h1234, ex_wr_reg=5, ex_ctrl=12'h0A1, ex_valid=1.
//  3 Stall: stall=1 for 3 cycles with changing id_* -> ex_* unchanged.
//    Drop stall with flush=1 -> bubble.
//    With STALL_CNT_EN: stall_cycles=3, flush_cycles=1.
//  4 HALT: load id_halt=1, id_valid=1 -> ex_halt=1, halted=1.
//    Then 2 stall cycles -> HALT held.
//    Then valid id_* for 3 cycles -> ex_valid=0 each cycle, halted stays 1.
//    Then rst -> halted=0.
//  5 Squash: flush=1 and id_halt=1, id_valid=1 on the same edge -> ex_valid=0, halted=0.
//  6 Saturation (STALL_CNT_EN): hold stall=1 for 65540 cycles -> stall_cycles=16'hFFFF.
//    Then rst -> 0.

Source files
------------

// File: rtl/id_ex_latch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// id_ex_latch : decode->execute pipeline register with stall, flush, sticky HALT
// Optional STALL_CNT_EN adds saturating stall/flush event counters.
// Revision   : 1.0
// ---------------------------------------------------------------------------
module id_ex_latch #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [15:0]       id_instr,
  input  logic [DATA_W-1:0] id_pc_plus2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [2:0]        id_wr_reg,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_halt,
  output logic              ex_valid,
  output logic [15:0]       ex_instr,
  output logic [DATA_W-1:0] ex_pc_plus2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [2:0]        ex_wr_reg,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_halt,
`ifdef STALL_CNT_EN
  output logic [15:0]       stall_cycles,
  output logic [15:0]       flush_cycles,
`endif
  output logic              halted
);

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic [15:0]         instr_q, instr_d;
  logic [DATA_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [DATA_W-1:0]   rd1_q, rd1_d;
  logic [DATA_W-1:0]   rd2_q, rd2_d;
  logic [2:0]          wr_reg_q, wr_reg_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic                halt_q, halt_d;

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    imm_d    = imm_q;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    wr_reg_d = wr_reg_q;
    ctrl_d   = ctrl_q;
    halt_d   = halt_q;
    if (!stall) begin
      // Once halted, nothing new enters execute until reset.
      if (state_q == ST_HALTED || flush || !id_valid) begin
        valid_d  = 1'b0;
        instr_d  = NOP_INSTR;
        pc_d     = '0;
        imm_d    = '0;
        rd1_d    = '0;
        rd2_d    = '0;
        wr_reg_d = '0;
        ctrl_d   = '0;
        halt_d   = 1'b0;
      end else begin
        valid_d  = 1'b1;
        instr_d  = id_instr;
        pc_d     = id_pc_plus2;
        imm_d    = id_imm;
        rd1_d    = id_rd1;
        rd2_d    = id_rd2;
        wr_reg_d = id_wr_reg;
        ctrl_d   = id_ctrl;
        halt_d   = id_halt;
        if (id_halt) begin
          state_d = ST_HALTED;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      valid_q  <= 1'b0;
      instr_q  <= NOP_INSTR;
      pc_q     <= '0;
      imm_q    <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      wr_reg_q <= '0;
      ctrl_q   <= '0;
      halt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      imm_q    <= imm_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      wr_reg_q <= wr_reg_d;
      ctrl_q   <= ctrl_d;
      halt_q   <= halt_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_instr    = instr_q;
  assign ex_pc_plus2 = pc_q;
  assign ex_imm      = imm_q;
  assign ex_rd1      = rd1_q;
  assign ex_rd2      = rd2_q;
  assign ex_wr_reg   = wr_reg_q;
  assign ex_ctrl     = ctrl_q;
  assign ex_halt     = halt_q;
  assign halted      = (state_q == ST_HALTED);

`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Counters saturate and freeze once the core has halted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q == ST_RUN) begin
      if (stall) begin
        if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
      end else if (flush) begin
        if (flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`endif

endmodule
`default_nettype wire
